alu32_result_checker: RTL
=========================

Name: alu32_result_checker

Overview:
- Response-side counterpart to the ALU stimulus generator.
- Samples each operand/opcode vector and the ALU's result, computes the expected result with an internal golden model, then compares the two.
- Counts passes, fails and skipped vectors, and latches the first mismatch for the Verilator harness to read back.
- Sits beside the 32-bit ALU under test and is clocked by the same sys_clk as the stimulus generator.

Parameters:
- RESULT_LAT, 1: cycles from a sampled vector to its alu_result being valid (0..4). 0 means combinational, compared in the same cycle.
- NUM_VECTORS, 64: number of compares after which the run ends.
- CNT_W, 16: width of the pass/fail/skip counters.

Ports:
- sys_clk  in  1  sole clock; all logic on posedge.
- sys_rst_n  in  1  synchronous, active-low reset, sampled on posedge sys_clk.
- start  in  1  pulse: begin a run (honoured in IDLE/DONE only).
- sample_valid  in  1  alu_ctrl/op_a/op_b are a vector this cycle.
- alu_ctrl  in  4  ALU opcode under test.
- op_a  in  32  operand A.
- op_b  in  32  operand B.
- alu_result  in  32  DUT result.
- alu_zero  in  1  DUT Zero flag.
- busy  out  1  high in RUN.
- done  out  1  high in DONE.
- mismatch  out  1  one-cycle pulse on a failing compare.
- pass_count  out  CNT_W  passing compares.
- fail_count  out  CNT_W  failing compares.
- skip_count  out  CNT_W  compares on opcode 15 (not checked).
- first_fail_ctrl  out  4  opcode of the first failure.
- first_fail_exp  out  32  expected value of the first failure.
- first_fail_got  out  32  alu_result at the first failure.

Behaviour:
- Reset (sys_rst_n=0 at posedge): state=IDLE; all outputs 0; delay pipe cleared. Reset mid-run aborts the run; partial counts are lost.
- FSM:
  - IDLE -start-> RUN: counters, first_fail_* and the pipe are cleared on entry.
  - RUN -(compares issued == NUM_VECTORS)-> DONE.
  - DONE -start-> RUN: same clearing as above.
  - start while in RUN is ignored. sample_valid is ignored outside RUN.
- Golden model (unsigned wrap, 32-bit):
  - 0 AND; 1 OR; 2 ADD; 3 XOR; 4 NOR; 5 SUB (A-B).
  - 6 SLT signed (result 1/0); 7 SLTU.
  - 8 SLL A<<B[4:0]; 9 SRL A>>B[4:0]; 10 SRA arithmetic A>>>B[4:0].
  - 11 MUL, low 32 bits of A*B.
  - 12 pass A; 13 pass B; 14 EQ (result 1 if A==B, else 0).
  - 15 unchecked: increments skip_count and never fails.
- Pipeline:
  - On sample_valid in RUN, {valid, ctrl, expected} enters a RESULT_LAT-deep shift register.
  - The compare happens on the cycle the entry exits, using alu_result at that posedge.
  - RESULT_LAT=0: compare in the sampling cycle.
  - Back-to-back samples every cycle are supported, with no bubbles.
- Compare:
  - equal → pass_count+1.
  - not equal → fail_count+1 and mismatch=1 for one cycle.
  - first_fail_* is written only on the first failure of a run.
- Vector limit:
  - The compare that brings the total to NUM_VECTORS moves the FSM to DONE on that edge.
  - Vectors sampled but not yet compared at that point are discarded.
  - New samples are not pushed once compares issued plus in-flight entries reach NUM_VECTORS.
- Counters saturate at all-ones and do not wrap.
- Counts and first_fail_* hold their values in DONE until the next start or reset.

Optional Feature:
- CHECK_ZERO_EN defined:
  - Each compare also requires alu_zero == (expected == 0); a flag error counts as a fail.
  - first_fail_got[0] is then unaffected; result fields are still reported.
- Undefined: alu_zero is ignored.

Test Plan:
- Reset, start, vectors (ctrl=2,A=2,B=2) then (ctrl=5,A=2,B=6), RESULT_LAT=1, correct DUT -> pass_count=2, fail_count=0, expected values 4 and 0xFFFFFFFC.
- DUT forced to return 0x5 for (ctrl=0,A=2,B=2) -> mismatch pulse one cycle after result; fail_count=1; first_fail_ctrl=0, first_fail_exp=2, first_fail_got=5; a later, second failure leaves first_fail_* unchanged.
- NUM_VECTORS=4, sample_valid held high 10 cycles -> done after exactly 4 compares; pass_count+fail_count+skip_count=4; busy=0.
- ctrl=15 vector, plus ctrl=10 with A=0x80000000, B=4 -> skip_count=1; SRA expected 0xF8000000 passes.
- sys_rst_n low for one cycle mid-run after 3 compares -> all counts 0, state IDLE; start re-runs cleanly.
- CHECK_ZERO_EN, ctrl=5 with A=B=7, DUT alu_zero=0 -> fail_count=1; same vector without the macro -> pass.

Source files
------------

// File: rtl/alu32_result_checker.sv
// Response checker for a 32-bit ALU: golden model, latency-matched compare, pass/fail/skip counting.
// Optional `CHECK_ZERO_EN also checks the ALU Zero flag against the expected result.
module alu32_result_checker #(
    parameter int RESULT_LAT  = 1,
    parameter int NUM_VECTORS = 64,
    parameter int CNT_W       = 16
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             start,
    input  logic             sample_valid,
    input  logic [3:0]       alu_ctrl,
    input  logic [31:0]      op_a,
    input  logic [31:0]      op_b,
    input  logic [31:0]      alu_result,
    input  logic             alu_zero,
    output logic             busy,
    output logic             done,
    output logic             mismatch,
    output logic [CNT_W-1:0] pass_count,
    output logic [CNT_W-1:0] fail_count,
    output logic [CNT_W-1:0] skip_count,
    output logic [3:0]       first_fail_ctrl,
    output logic [31:0]      first_fail_exp,
    output logic [31:0]      first_fail_got
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic        vld;
        logic [3:0]  ctrl;
        logic [31:0] exp;
    } pipe_ent_t;

    // A zero-latency build keeps one dummy stage so the array is never empty.
    localparam int PIPE_D = (RESULT_LAT == 0) ? 1 : RESULT_LAT;
    localparam int ISS_W  = $clog2(NUM_VECTORS + 1) + 1;
    localparam logic [ISS_W-1:0] NUM_V   = ISS_W'(NUM_VECTORS);
    localparam logic [ISS_W-1:0] ISS_ONE = {{(ISS_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam pipe_ent_t PIPE_EMPTY = '{vld: 1'b0, ctrl: 4'd0, exp: 32'd0};

    function automatic logic [31:0] golden(input logic [3:0] ctrl,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
        logic [31:0] r;
        case (ctrl)
            4'd0:    r = a & b;
            4'd1:    r = a | b;
            4'd2:    r = a + b;
            4'd3:    r = a ^ b;
            4'd4:    r = ~(a | b);
            4'd5:    r = a - b;
            4'd6:    r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd7:    r = (a < b) ? 32'd1 : 32'd0;
            4'd8:    r = a << b[4:0];
            4'd9:    r = a >> b[4:0];
            4'd10:   r = $unsigned($signed(a) >>> b[4:0]);
            4'd11:   r = a * b;
            4'd12:   r = a;
            4'd13:   r = b;
            4'd14:   r = (a == b) ? 32'd1 : 32'd0;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_ONE;
    endfunction

    state_t            state_q, state_d;
    pipe_ent_t         pipe_q [PIPE_D];
    pipe_ent_t         pipe_d [PIPE_D];
    logic [ISS_W-1:0]  issued_q, issued_d;
    logic [CNT_W-1:0]  pass_q, pass_d, fail_q, fail_d, skip_q, skip_d;
    logic              mismatch_q, mismatch_d;
    logic              busy_q, busy_d, done_q, done_d;
    logic [3:0]        ff_ctrl_q, ff_ctrl_d;
    logic [31:0]       ff_exp_q, ff_exp_d, ff_got_q, ff_got_d;

    logic [ISS_W-1:0]  inflight_s;
    pipe_ent_t         push_ent_s;
    pipe_ent_t         exit_ent_s;
    logic              cmp_s;
    logic              skip_s;
    logic              ok_s;

    // Push/exit entry selection and compare qualification.
    always_comb begin
        inflight_s = {ISS_W{1'b0}};
        for (int i = 0; i < PIPE_D; i++) begin
            inflight_s = inflight_s + {{(ISS_W-1){1'b0}}, pipe_q[i].vld};
        end
        push_ent_s.vld  = (state_q == ST_RUN) && sample_valid &&
                          ((issued_q + inflight_s) < NUM_V);
        push_ent_s.ctrl = alu_ctrl;
        push_ent_s.exp  = golden(alu_ctrl, op_a, op_b);
        if (RESULT_LAT == 0) begin
            exit_ent_s = push_ent_s;
        end else begin
            exit_ent_s = pipe_q[PIPE_D-1];
        end
        cmp_s  = (state_q == ST_RUN) && exit_ent_s.vld;
        skip_s = (exit_ent_s.ctrl == 4'd15);
`ifdef CHECK_ZERO_EN
        ok_s   = (alu_result == exit_ent_s.exp) &&
                 (alu_zero == (exit_ent_s.exp == 32'd0));
`else
        ok_s   = (alu_result == exit_ent_s.exp);
`endif
    end

    // Next-state, pipeline shift and counter update.
    always_comb begin
        state_d    = state_q;
        pipe_d     = pipe_q;
        issued_d   = issued_q;
        pass_d     = pass_q;
        fail_d     = fail_q;
        skip_d     = skip_q;
        mismatch_d = 1'b0;
        ff_ctrl_d  = ff_ctrl_q;
        ff_exp_d   = ff_exp_q;
        ff_got_d   = ff_got_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d   = ST_RUN;
                    issued_d  = {ISS_W{1'b0}};
                    pass_d    = CNT_ZERO;
                    fail_d    = CNT_ZERO;
                    skip_d    = CNT_ZERO;
                    ff_ctrl_d = 4'd0;
                    ff_exp_d  = 32'd0;
                    ff_got_d  = 32'd0;
                    for (int i = 0; i < PIPE_D; i++) pipe_d[i] = PIPE_EMPTY;
                end else begin
                    state_d = state_q;
                end
            end
            ST_RUN: begin
                for (int i = PIPE_D - 1; i > 0; i--) pipe_d[i] = pipe_q[i-1];
                pipe_d[0] = (RESULT_LAT == 0) ? PIPE_EMPTY : push_ent_s;
                if (cmp_s) begin
                    issued_d = issued_q + ISS_ONE;
                    if (skip_s) begin
                        skip_d = sat_inc(skip_q);
                    end else if (ok_s) begin
                        pass_d = sat_inc(pass_q);
                    end else begin
                        fail_d     = sat_inc(fail_q);
                        mismatch_d = 1'b1;
                        // Saturating fail count never returns to zero, so it doubles as "first seen".
                        if (fail_q == CNT_ZERO) begin
                            ff_ctrl_d = exit_ent_s.ctrl;
                            ff_exp_d  = exit_ent_s.exp;
                            ff_got_d  = alu_result;
                        end else begin
                            ff_ctrl_d = ff_ctrl_q;
                        end
                    end
                end else begin
                    issued_d = issued_q;
                end
                if (issued_d == NUM_V) begin
                    state_d = ST_DONE;
                    for (int i = 0; i < PIPE_D; i++) pipe_d[i] = PIPE_EMPTY;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q    <= ST_IDLE;
            for (int i = 0; i < PIPE_D; i++) pipe_q[i] <= PIPE_EMPTY;
            issued_q   <= {ISS_W{1'b0}};
            pass_q     <= CNT_ZERO;
            fail_q     <= CNT_ZERO;
            skip_q     <= CNT_ZERO;
            mismatch_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ff_ctrl_q  <= 4'd0;
            ff_exp_q   <= 32'd0;
            ff_got_q   <= 32'd0;
        end else begin
            state_q    <= state_d;
            for (int i = 0; i < PIPE_D; i++) pipe_q[i] <= pipe_d[i];
            issued_q   <= issued_d;
            pass_q     <= pass_d;
            fail_q     <= fail_d;
            skip_q     <= skip_d;
            mismatch_q <= mismatch_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ff_ctrl_q  <= ff_ctrl_d;
            ff_exp_q   <= ff_exp_d;
            ff_got_q   <= ff_got_d;
        end
    end

    assign busy            = busy_q;
    assign done            = done_q;
    assign mismatch        = mismatch_q;
    assign pass_count      = pass_q;
    assign fail_count      = fail_q;
    assign skip_count      = skip_q;
    assign first_fail_ctrl = ff_ctrl_q;
    assign first_fail_exp  = ff_exp_q;
    assign first_fail_got  = ff_got_q;

endmodule
